// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage: instruction-fetch stage of a simple in-order pipeline.
//   Holds the PC, presents it to the instruction memory, and captures the
//   returned word into the IF/ID register. Priority per cycle:
//   reset > redirect > stall > normal advance.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   stall_i        hold PC and IF/ID
//   redirect_i     taken branch/jump: load redirect_pc_i, flush IF/ID
//   redirect_pc_i  redirect target (bits [1:0] ignored)
//   imem_addr_o    current PC, straight from the PC register
//   imem_instr_i   instruction word for imem_addr_o (combinational memory)
//   id_pc_o        PC of the IF/ID instruction
//   id_pc4_o       id_pc_o + 4
//   id_instr_o     IF/ID instruction (NOP when bubble)
//   id_valid_o     IF/ID holds a real instruction
//   fetch_cnt_o    normal-advance count (0 unless IF_PERF_CNT_EN)
//   stall_cnt_o    stall-cycle count   (0 unless IF_PERF_CNT_EN)
//
// Build option
//   IF_PERF_CNT_EN  when defined, instantiates the fetch/stall counters.
// ---------------------------------------------------------------------------
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_instr_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_pc4_o,
   output logic [31:0] id_instr_o,
   output logic        id_valid_o,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] stall_cnt_o
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_STEP      = 32'd4;
   localparam logic [XLEN-1:0] RESET_PC_ALN = {RESET_PC[XLEN-1:2], 2'b00};

   logic [XLEN-1:0] pc_q,       pc_d;
   logic [XLEN-1:0] id_pc_q,    id_pc_d;
   logic [XLEN-1:0] id_pc4_q,   id_pc4_d;
   logic [XLEN-1:0] id_instr_q, id_instr_d;
   logic            id_valid_q, id_valid_d;

   // Next-state for PC and IF/ID: redirect flushes, stall holds, else advance.
   always_comb begin
      pc_d       = pc_q;
      id_pc_d    = id_pc_q;
      id_pc4_d   = id_pc4_q;
      id_instr_d = id_instr_q;
      id_valid_d = id_valid_q;
      if (redirect_i) begin
         pc_d       = {redirect_pc_i[XLEN-1:2], 2'b00};
         id_pc_d    = '0;
         id_pc4_d   = '0;
         id_instr_d = NOP_INSTR;
         id_valid_d = 1'b0;
      end else if (!stall_i) begin
         // PC + 4 wraps naturally at 2^32
         pc_d       = pc_q + PC_STEP;
         id_pc_d    = pc_q;
         id_pc4_d   = pc_q + PC_STEP;
         id_instr_d = imem_instr_i;
         id_valid_d = 1'b1;
      end
   end

   // PC and IF/ID registers; reset loads the aligned reset PC and a bubble.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q       <= RESET_PC_ALN;
         id_pc_q    <= '0;
         id_pc4_q   <= '0;
         id_instr_q <= NOP_INSTR;
         id_valid_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         id_pc_q    <= id_pc_d;
         id_pc4_q   <= id_pc4_d;
         id_instr_q <= id_instr_d;
         id_valid_q <= id_valid_d;
      end
   end

   assign imem_addr_o = pc_q;
   assign id_pc_o     = id_pc_q;
   assign id_pc4_o    = id_pc4_q;
   assign id_instr_o  = id_instr_q;
   assign id_valid_o  = id_valid_q;

`ifdef IF_PERF_CNT_EN
   logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
   logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;

   // A redirect cycle counts as neither a fetch nor a stall.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (!redirect_i) begin
         if (stall_i) begin
            stall_cnt_d = stall_cnt_q + XLEN'(1);
         end else begin
            fetch_cnt_d = fetch_cnt_q + XLEN'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fetch_cnt_o = fetch_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
`else
   assign fetch_cnt_o = '0;
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage: scoreboard bench for if_stage. Two instances share stimulus:
//   dut0 with RESET_PC = 0, dut1 with RESET_PC = 32'hFFFF_FFFF (low bits must
//   be dropped, giving the 32'hFFFF_FFFC wrap case). Instruction memory
//   returns word index (addr >> 2). The driver advances a reference model and
//   queues expected outputs; the monitor compares one cycle later.
// ---------------------------------------------------------------------------
module tb_if_stage;

   localparam logic [31:0] RPC0 = 32'h0000_0000;
   localparam logic [31:0] RPC1 = 32'hFFFF_FFFF;
`ifdef IF_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] id_pc;
      logic [31:0] id_pc4;
      logic [31:0] instr;
      logic        valid;
      logic [31:0] fcnt;
      logic [31:0] scnt;
   } obs_t;

   logic        clk;
   logic        rst, stall, redirect;
   logic [31:0] redirect_pc;
   logic [31:0] addr0, instr0, id_pc0, id_pc40, id_instr0, fcnt0, scnt0;
   logic [31:0] addr1, instr1, id_pc1, id_pc41, id_instr1, fcnt1, scnt1;
   logic        valid0, valid1;

   obs_t exp_q0[$];
   obs_t exp_q1[$];
   obs_t m0, m1, e0, e1;
   int   n_checks = 0;
   int   n_fail   = 0;

   assign instr0 = addr0 >> 2;
   assign instr1 = addr1 >> 2;

   if_stage #(.RESET_PC(RPC0)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
      .redirect_pc_i(redirect_pc), .imem_addr_o(addr0), .imem_instr_i(instr0),
      .id_pc_o(id_pc0), .id_pc4_o(id_pc40), .id_instr_o(id_instr0),
      .id_valid_o(valid0), .fetch_cnt_o(fcnt0), .stall_cnt_o(scnt0)
   );

   if_stage #(.RESET_PC(RPC1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
      .redirect_pc_i(redirect_pc), .imem_addr_o(addr1), .imem_instr_i(instr1),
      .id_pc_o(id_pc1), .id_pc4_o(id_pc41), .id_instr_o(id_instr1),
      .id_valid_o(valid1), .fetch_cnt_o(fcnt1), .stall_cnt_o(scnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: what the stage should hold after one clock, from the rules.
   function automatic obs_t step(input obs_t s, input logic r, input logic st,
                                 input logic rd, input logic [31:0] rp,
                                 input logic [31:0] reset_pc);
      obs_t n = s;
      if (r || rd) begin
         n.addr   = r ? (reset_pc & ~32'd3) : (rp & ~32'd3);
         n.id_pc  = 32'd0;
         n.id_pc4 = 32'd0;
         n.instr  = 32'h13;
         n.valid  = 1'b0;
         if (r) begin
            n.fcnt = 32'd0;
            n.scnt = 32'd0;
         end
      end else if (st) begin
         if (PERF) n.scnt = s.scnt + 32'd1;
      end else begin
         n.id_pc  = s.addr;
         n.id_pc4 = s.addr + 32'd4;
         n.instr  = s.addr / 4;
         n.valid  = 1'b1;
         n.addr   = s.addr + 32'd4;
         if (PERF) n.fcnt = s.fcnt + 32'd1;
      end
      return n;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
      check({tag, ".imem_addr"}, a.addr,   e.addr);
      check({tag, ".id_pc"},     a.id_pc,  e.id_pc);
      check({tag, ".id_pc4"},    a.id_pc4, e.id_pc4);
      check({tag, ".id_instr"},  a.instr,  e.instr);
      check({tag, ".id_valid"},  32'(a.valid), 32'(e.valid));
      check({tag, ".fetch_cnt"}, a.fcnt,   e.fcnt);
      check({tag, ".stall_cnt"}, a.scnt,   e.scnt);
   endtask

   // Monitor: one expected entry per clock edge, sampled 1 time unit after it.
   always @(posedge clk) begin
      #1;
      if (exp_q0.size() > 0 && exp_q1.size() > 0) begin
         e0 = exp_q0.pop_front();
         e1 = exp_q1.pop_front();
         cmp_obs("dut0", {addr0, id_pc0, id_pc40, id_instr0, valid0, fcnt0, scnt0}, e0);
         cmp_obs("dut1", {addr1, id_pc1, id_pc41, id_instr1, valid1, fcnt1, scnt1}, e1);
      end
   end

   // Driver: apply inputs for the next edge and queue the predicted result.
   task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] rp);
      @(posedge clk);
      #3;
      rst         = r;
      stall       = s;
      redirect    = rd;
      redirect_pc = rp;
      m0 = step(m0, r, s, rd, rp, RPC0);
      m1 = step(m1, r, s, rd, rp, RPC1);
      exp_q0.push_back(m0);
      exp_q1.push_back(m1);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'd0);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
      m0 = '0; m1 = '0;

      // Reset then free-running fetch
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      run(6);

      // Stall 3 cycles with id_pc = 8
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      run(3);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 32'd0);
      run(2);

      // Redirects, aligned and misaligned targets
      drive(1'b0, 1'b0, 1'b1, 32'h40);
      run(2);
      drive(1'b0, 1'b0, 1'b1, 32'h43);
      run(2);

      // Redirect together with stall
      drive(1'b0, 1'b1, 1'b1, 32'h20);
      run(2);

      // Redirect held for three cycles with moving target
      drive(1'b0, 1'b0, 1'b1, 32'h100);
      drive(1'b0, 1'b0, 1'b1, 32'h204);
      drive(1'b0, 1'b1, 1'b1, 32'h30B);
      run(2);

      // Redirect right after a stall
      drive(1'b0, 1'b1, 1'b0, 32'd0);
      drive(1'b0, 1'b0, 1'b1, 32'h80);
      run(2);

      // Wrap through address zero
      drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
      run(4);

      // Reset asserted mid-stall/mid-redirect after 10 fetches
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      run(10);
      drive(1'b0, 1'b1, 1'b0, 32'd0);
      drive(1'b1, 1'b1, 1'b1, 32'h500);
      run(3);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 5) == 0, $urandom());
      end
      drive(1'b0, 1'b0, 1'b0, 32'd0);

      @(posedge clk);
      #2;
      check("scoreboard_drain", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC loaded on reset; bits [1:0] SHALL be treated as zero.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 stall_i  input  1  hold request from the decode/hazard logic.
REQ-005 redirect_i  input  1  taken branch/jump; replaces the next PC and flushes IF/ID.
REQ-006 redirect_pc_i  input  32  redirect target address.
REQ-007 imem_addr_o  output  32  byte address to the instruction memory, equal to the current PC.
REQ-008 imem_instr_i  input  32  instruction word returned combinationally by the memory for imem_addr_o (word index = address >> 2).
REQ-009 id_pc_o  output  32  PC of the instruction held in IF/ID.
REQ-010 id_pc4_o  output  32  id_pc_o + 4, modulo 2^32.
REQ-011 id_instr_o  output  32  instruction held in IF/ID.
REQ-012 id_valid_o  output  1  IF/ID holds a real instruction (1) or a bubble (0).
REQ-013 fetch_cnt_o  output  32  count of fetched instructions (see Configuration).
REQ-014 stall_cnt_o  output  32  count of stall cycles (see Configuration).

Function
REQ-015 imem_addr_o SHALL be driven directly from the PC register, with no combinational path from any input.
REQ-016 Priority each cycle SHALL be: rst_i > redirect_i > stall_i > normal advance.
REQ-017 Normal advance: PC <= PC + 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000; IF/ID <= {PC, PC+4, imem_instr_i, valid=1}.
REQ-018 Redirect: PC <= {redirect_pc_i[31:2], 2'b00}; IF/ID SHALL load a bubble: id_instr_o = 32'h0000_0013 (NOP), id_pc_o = 0, id_pc4_o = 0, id_valid_o = 0.
REQ-019 Redirect asserted together with stall_i SHALL behave as redirect only; the stall is ignored.
REQ-020 Stall without redirect: PC and all IF/ID fields SHALL hold their values.
REQ-021 Latency: the word addressed by imem_addr_o = A in cycle n SHALL appear on id_instr_o, with id_pc_o = A, in cycle n+1, unless stall, redirect or reset occurs in cycle n.
REQ-022 Redirect held for k consecutive cycles SHALL produce k consecutive bubbles, and PC SHALL track redirect_pc_i each cycle.
REQ-023 A redirect in the cycle after a stall SHALL discard the held IF/ID contents.

Reset
REQ-024 With rst_i high at a clock edge: PC <= RESET_PC with [1:0] = 0; IF/ID <= bubble (per REQ-018); fetch_cnt_o and stall_cnt_o <= 0.
REQ-025 Reset asserted mid-stall or mid-redirect SHALL override both; the first cycle after release SHALL present imem_addr_o = RESET_PC and id_valid_o = 0.

Configuration
REQ-026 Macro IF_PERF_CNT_EN: when defined, fetch_cnt_o SHALL increment, wrapping modulo 2^32, on every normal-advance cycle (REQ-017), and stall_cnt_o SHALL increment, wrapping modulo 2^32, on every cycle with stall_i=1 and redirect_i=0 and rst_i=0.
REQ-027 When IF_PERF_CNT_EN is undefined, fetch_cnt_o and stall_cnt_o SHALL be constant 0, no counter registers SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-028 Reset sequence: RESET_PC=0, memory word i = i; release reset, no stall or redirect -> imem_addr_o = 0,4,8,...; id_instr_o = 0,1,2,... one cycle behind; id_valid_o = 0 then 1.
REQ-029 Stall: stall_i high for 3 cycles while id_pc_o = 8 -> imem_addr_o holds 12, IF/ID holds pc 8 for 3 cycles, then advances; stall_cnt_o += 3 (macro on).
REQ-030 Redirect: redirect_i=1 with redirect_pc_i=32'h40 (and separately 32'h43) -> next cycle imem_addr_o = 32'h40 and id_instr_o = 32'h13, id_valid_o = 0; the following cycle id_pc_o = 32'h40, id_valid_o = 1.
REQ-031 Simultaneous: redirect_i=1 and stall_i=1 with target 32'h20 -> bubble and PC = 32'h20; stall_cnt_o unchanged.
REQ-032 Wrap: RESET_PC = 32'hFFFF_FFFC -> second fetch address is 32'h0; id_pc4_o = 0 for the instruction at 32'hFFFF_FFFC.
REQ-033 Reset mid-operation: assert rst_i during a stall after 10 fetches -> PC = RESET_PC, id_valid_o = 0, both counters = 0; build with and without IF_PERF_CNT_EN -> counters constant 0 in the disabled build.
